udp_ip_tx_framer: RTL and testbench
===================================

# udp_ip_tx_framer

Parametrised multi-channel UDP/IPv4 transmit framer. Replaces the single-channel `udp_ip_stack` packet assembly. Arbitrates round-robin between `NUM_CH` payload streams, prepends a 28-byte IPv4 + UDP header (seven 32-bit words), and streams the frame to the MAC with valid/ready backpressure. Adds per-packet IP identification, byte-granular length with `out_keep`, length-error detection and an optional IPv4 header checksum stage.

## Interface
- `NUM_CH`, 2: number of input channels, 1..8.
- `MAX_PAYLOAD`, 1472: maximum UDP payload in bytes. Larger packets are dropped.
- `TTL`, 64: IPv4 time-to-live value.
- `clk`  in  1  125 MHz GMII-domain clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  NUM_CH*32  per-channel payload word; channel c occupies `[32c+31:32c]`. Big-endian: first byte in `[31:24]`.
- `in_len`  in  NUM_CH*16  per-channel payload length in bytes. Must be valid with the first word.
- `in_valid`  in  NUM_CH  per-channel word valid.
- `in_last`  in  NUM_CH  per-channel final word of the packet.
- `in_ready`  out  NUM_CH  per-channel word accepted when valid&ready.
- `src_ip`, `dst_ip`  in  32  IPv4 addresses, sampled at grant.
- `src_port`  in  16  UDP source port, sampled at grant.
- `dst_port_base`  in  16  channel c uses destination port `dst_port_base + c`, mod 2^16.
- `out_data`  out  32  frame word to MAC.
- `out_keep`  out  4  byte enables; bit 3 = `[31:24]`.
- `out_valid`  out  1  frame word valid.
- `out_last`  out  1  final word of the frame.
- `out_ready`  in  1  MAC accepts the word.
- `out_len`  out  16  IPv4 total length (28 + payload). Held from the first header word until the next grant.
- `err_len`  out  1  one-cycle pulse on any length error.

## Operation
- States: IDLE, CALC, HDR, PAY, DROP.
- **IDLE**
  - Pick a requesting channel round-robin, starting at (last grant + 1) mod NUM_CH. The pointer resets to 0.
  - Latch the channel, `in_len`, addresses and ports.
  - If `len == 0` or `len > MAX_PAYLOAD`: go to DROP. Otherwise go to CALC.
- **CALC** (2 cycles)
  - Cycle 1: sum the header 16-bit fields into a 20-bit accumulator, with the checksum field taken as 0.
  - Cycle 2: fold the carries twice and invert.
- **HDR**: emit W0–W6, each held until `out_ready`.
  - W0 = {0x45, 0x00, total_len}
  - W1 = {ident, 0x4000}
  - W2 = {TTL, 0x11, csum}
  - W3 = src_ip
  - W4 = dst_ip
  - W5 = {src_port, dst_port}
  - W6 = {8 + len, 0x0000}
  - W0–W6 have `out_keep = 4'hF` and `out_last = 0`.
- **PAY**
  - Pass-through: `out_valid = in_valid[g]`, `in_ready[g] = out_ready`, `out_data = in_data[g]`.
  - Expected word count is ceil(len/4).
  - On the final expected word, `out_keep` = {1111, 1000, 1100, 1110}[len mod 4] and `out_last = 1`.
- **Length errors**
  - Early `in_last` (before the expected count): force `out_last` on that word with `keep = F`, pulse `err_len`, go to IDLE.
  - Count reached without `in_last`: still emit `out_last`, pulse `err_len`, go to DROP.
- **DROP**
  - `in_ready[g] = 1`, no output.
  - Consume words until `in_last`, then go to IDLE.
  - Zero/oversize packets pulse `err_len` on grant.
- **ident**: 16-bit counter, incremented when W1 transfers; wraps from 0xFFFF to 0x0000. Dropped packets do not consume an ident.
- `in_ready` is 0 for non-granted channels and outside PAY/DROP.

## Timing
- Reset values: `out_valid`, `out_last`, `in_ready`, `err_len` = 0; `out_data`, `out_keep`, `out_len`, `ident` = 0. State is IDLE, RR pointer is 0.
- Grant cycle T: W0 `out_valid` is at T+3 with the checksum enabled, T+1 without.
- Header registers are stable while `out_valid && !out_ready`.
- Back-to-back: the last PAY beat transfers at cycle N; the next grant is at N+1.
- Reset mid-packet aborts immediately. The partial frame is not completed, and the granted channel's remaining words are not drained.

## Configuration
- `UDP_IP_TX_CHECKSUM_EN` defined: CALC state present, W2 `csum` is computed.
- `UDP_IP_TX_CHECKSUM_EN` undefined: CALC is skipped (IDLE goes straight to HDR), `csum = 0x0000` for MAC checksum offload, and grant-to-W0 latency is 1.

## Structure
- Package `udp_ip_pkg`:
  - state enum
  - header constants: `IP_VER_IHL = 8'h45`, `IP_PROTO_UDP = 8'h11`, `IP_FLAGS_DF = 16'h4000`, `HDR_WORDS = 7`, `HDR_BYTES = 28`
  - function `keep_from_len`
- Sub-module `rr_arbiter` (NUM_CH requests, grant one-hot + index, advance on packet start).

## Test plan
- Single packet on ch0: `0xDEADBEEF`, len 4, src_ip 0xC0A80101, dst_ip 0xC0A80102, ports 12345/12346, ident 0 -> W0 0x45000020, W1 0x00004000, W2 0x4011B779, W6 0x000C0000, W7 0xDEADBEEF with keep F and last; `out_len` 32.
- len 5 -> two payload words, the last with keep 4'b1000; W0 total length 0x0021.
- ch0 and ch1 request in the same cycle -> ch0 frame (ident 0, dst port base+0), then ch1 frame (ident 1, port base+1) starting the cycle after ch0's last beat.
- `out_ready` toggling 1/0 every cycle -> all words unchanged while stalled; frame content identical to the unstalled run.
- len 0 and len 1500 -> one `err_len` pulse each, `out_valid` never asserted, input drained through `in_last`. Early `in_last` on a len-12 packet after 2 words -> `out_last` on the 2nd payload word plus `err_len`.
- Build without `UDP_IP_TX_CHECKSUM_EN` -> W2 = 0x40110000, W0 at grant+1. Reset asserted during PAY -> all outputs 0 on the next edge, next packet framed cleanly with ident 0.

Source files
------------

// File: rtl/udp_ip_pkg.sv
// Shared types and constants for the UDP/IPv4 transmit framer.
// Contents: FSM state codes, IPv4/UDP header constants, latched header
// payload struct, and the final-word byte-enable helper.
package udp_ip_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_CALC = 3'd1;
    localparam state_t ST_HDR  = 3'd2;
    localparam state_t ST_PAY  = 3'd3;
    localparam state_t ST_DROP = 3'd4;

    localparam logic [7:0]  IP_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
    localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;
    localparam int unsigned HDR_WORDS    = 7;
    localparam int unsigned HDR_BYTES    = 28;

    // Per-packet fields captured at grant
    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] len;
    } hdr_t;

    // Byte enables for the final payload word of a len-byte packet
    function automatic logic [3:0] keep_from_len(input logic [15:0] len);
        case (len[1:0])
            2'd0:    return 4'b1111;
            2'd1:    return 4'b1000;
            2'd2:    return 4'b1100;
            default: return 4'b1110;
        endcase
    endfunction

endpackage

// File: rtl/udp_ip_tx_framer_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward for the first
// requester; the pointer moves past the winner when i_advance is high.
// Ports: i_req (requests), i_advance (packet start), o_grant_c (one-hot),
// o_idx_c (winner index), o_any_c (some request present).
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CW     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_grant_c,
    output logic [CW-1:0]     o_idx_c,
    output logic              o_any_c
);
    logic [CW-1:0] r_ptr;
    int unsigned   w_j;

    // Priority search starting at r_ptr
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        w_j       = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_j = (32'(r_ptr) + i) % NUM_CH;
            if (!o_any_c && i_req[w_j]) begin
                o_any_c        = 1'b1;
                o_idx_c        = CW'(w_j);
                o_grant_c[w_j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (i_advance && o_any_c)
            r_ptr <= CW'((32'(o_idx_c) + 1) % NUM_CH);
    end

endmodule

// File: rtl/udp_ip_tx_framer.sv
// Multi-channel UDP/IPv4 transmit framer: round-robin grant, 7-word
// IPv4+UDP header, payload pass-through with byte keep, length-error drop.
// Optional macro UDP_IP_TX_CHECKSUM_EN enables the 2-cycle header checksum
// stage; otherwise the checksum field is 0 (MAC offload).
// Ports: clk/rst_n; in_* per-channel payload streams (in_ready back);
// src_ip/dst_ip/src_port/dst_port_base header fields; out_* MAC stream;
// out_len IPv4 total length; err_len length-error pulse.
module udp_ip_tx_framer
    import udp_ip_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter int unsigned TTL         = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH*32-1:0]   in_data,
    input  logic [NUM_CH*16-1:0]   in_len,
    input  logic [NUM_CH-1:0]      in_valid,
    input  logic [NUM_CH-1:0]      in_last,
    output logic [NUM_CH-1:0]      in_ready,
    input  logic [31:0]            src_ip,
    input  logic [31:0]            dst_ip,
    input  logic [15:0]            src_port,
    input  logic [15:0]            dst_port_base,
    output logic [31:0]            out_data,
    output logic [3:0]             out_keep,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [15:0]            out_len,
    output logic                   err_len
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            r_state, w_next;
    hdr_t              r_hdr;
    logic [CW-1:0]     r_ch;
    logic [NUM_CH-1:0] r_gnt;
    logic [15:0]       r_ident, r_nwords, r_pcnt, r_out_len;
    logic [2:0]        r_widx;
    logic              r_err;

    logic [NUM_CH-1:0] w_gnt_oh;
    logic [CW-1:0]     w_gnt_idx;
    logic              w_gnt_any, w_grant, w_len_bad;
    logic [15:0]       w_len_new, w_csum;
    logic [31:0]       w_pay_data, w_hdr_word;
    logic              w_pay_valid, w_pay_last, w_last_exp, w_pay_xfer;

    rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (in_valid),
        .i_advance (w_grant),
        .o_grant_c (w_gnt_oh),
        .o_idx_c   (w_gnt_idx),
        .o_any_c   (w_gnt_any)
    );

    assign w_grant     = (r_state == ST_IDLE) && w_gnt_any;
    assign w_len_new   = in_len[16*32'(w_gnt_idx) +: 16];
    assign w_len_bad   = (w_len_new == 16'd0) || (32'(w_len_new) > MAX_PAYLOAD);
    assign w_pay_data  = in_data[32*32'(r_ch) +: 32];
    assign w_pay_valid = in_valid[r_ch];
    assign w_pay_last  = in_last[r_ch];
    assign w_last_exp  = (r_pcnt == r_nwords - 16'd1);
    assign w_pay_xfer  = (r_state == ST_PAY) && w_pay_valid && out_ready;

`ifdef UDP_IP_TX_CHECKSUM_EN
    logic        r_calc_ph;
    logic [19:0] r_sum;
    logic [15:0] r_csum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // A 20-bit sum of ten fields folds to 16 bits in two steps
    assign w_fold1 = 17'(r_sum[15:0]) + 17'(r_sum[19:16]);
    assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    assign w_csum  = r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_calc_ph <= 1'b0;
            r_sum     <= '0;
            r_csum    <= '0;
        end else if (r_state == ST_CALC) begin
            if (!r_calc_ph) begin
                r_sum <= 20'({IP_VER_IHL, 8'h00}) + 20'(r_out_len) + 20'(r_ident)
                       + 20'(IP_FLAGS_DF) + 20'({8'(TTL), IP_PROTO_UDP})
                       + 20'(r_hdr.src_ip[31:16]) + 20'(r_hdr.src_ip[15:0])
                       + 20'(r_hdr.dst_ip[31:16]) + 20'(r_hdr.dst_ip[15:0]);
                r_calc_ph <= 1'b1;
            end else begin
                r_csum    <= ~w_fold2;
                r_calc_ph <= 1'b0;
            end
        end
    end
`else
    assign w_csum = 16'h0000;
`endif

    // Header word select
    always_comb begin
        w_hdr_word = '0;
        case (r_widx)
            3'd0:    w_hdr_word = {IP_VER_IHL, 8'h00, r_out_len};
            3'd1:    w_hdr_word = {r_ident, IP_FLAGS_DF};
            3'd2:    w_hdr_word = {8'(TTL), IP_PROTO_UDP, w_csum};
            3'd3:    w_hdr_word = r_hdr.src_ip;
            3'd4:    w_hdr_word = r_hdr.dst_ip;
            3'd5:    w_hdr_word = {r_hdr.src_port, r_hdr.dst_port};
            default: w_hdr_word = {16'd8 + r_hdr.len, 16'h0000};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_any) begin
`ifdef UDP_IP_TX_CHECKSUM_EN
                    w_next = w_len_bad ? ST_DROP : ST_CALC;
`else
                    w_next = w_len_bad ? ST_DROP : ST_HDR;
`endif
                end
            end
`ifdef UDP_IP_TX_CHECKSUM_EN
            ST_CALC: if (r_calc_ph) w_next = ST_HDR;
`endif
            ST_HDR:  if (out_ready && (r_widx == 3'(HDR_WORDS - 1))) w_next = ST_PAY;
            ST_PAY: begin
                if (w_pay_xfer) begin
                    if (w_pay_last)      w_next = ST_IDLE;
                    else if (w_last_exp) w_next = ST_DROP;
                end
            end
            ST_DROP: if (w_pay_valid && w_pay_last) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output stream: header from registers, payload passed straight through
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_keep  = '0;
        out_last  = 1'b0;
        in_ready  = '0;
        case (r_state)
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = w_hdr_word;
                out_keep  = 4'hF;
            end
            ST_PAY: begin
                out_valid = w_pay_valid;
                out_data  = w_pay_data;
                out_keep  = w_last_exp ? keep_from_len(r_hdr.len) : 4'hF;
                out_last  = w_last_exp || w_pay_last;
                in_ready  = r_gnt & {NUM_CH{out_ready}};
            end
            ST_DROP: in_ready = r_gnt;
            default: ;
        endcase
    end

    assign out_len = r_out_len;
    assign err_len = r_err;

    // Grant capture, header/payload counters, ident, error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr     <= '0;
            r_ch      <= '0;
            r_gnt     <= '0;
            r_out_len <= '0;
            r_nwords  <= '0;
            r_pcnt    <= '0;
            r_widx    <= '0;
            r_ident   <= '0;
            r_err     <= 1'b0;
        end else begin
            // Early in_last, or count reached without in_last
            r_err <= (w_grant && w_len_bad) || (w_pay_xfer && (w_pay_last != w_last_exp));
            if (w_grant) begin
                r_ch           <= w_gnt_idx;
                r_gnt          <= w_gnt_oh;
                r_hdr.src_ip   <= src_ip;
                r_hdr.dst_ip   <= dst_ip;
                r_hdr.src_port <= src_port;
                r_hdr.dst_port <= dst_port_base + 16'(w_gnt_idx);
                r_hdr.len      <= w_len_new;
                r_out_len      <= 16'(HDR_BYTES) + w_len_new;
                r_nwords       <= 16'((17'(w_len_new) + 17'd3) >> 2);
                r_pcnt         <= '0;
                r_widx         <= '0;
            end
            if ((r_state == ST_HDR) && out_ready) begin
                r_widx <= r_widx + 3'd1;
                if (r_widx == 3'd1) r_ident <= r_ident + 16'd1;
            end
            if (w_pay_xfer) r_pcnt <= r_pcnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_udp_ip_tx_framer.sv
// Self-checking bench for udp_ip_tx_framer: per-channel packet queues,
// randomized valid gaps and out_ready, and a frame-level reference model.
module tb_udp_ip_tx_framer;
    localparam int NCH = 2;
    localparam int MAXP = 1472;
`ifdef UDP_IP_TX_CHECKSUM_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic [15:0] len;
        logic        first;
    } word_t;

    logic              clk, rst_n;
    logic [NCH*32-1:0] in_data;
    logic [NCH*16-1:0] in_len;
    logic [NCH-1:0]    in_valid, in_last, in_ready;
    logic [31:0]       src_ip, dst_ip;
    logic [15:0]       src_port, dst_port_base;
    logic [31:0]       out_data;
    logic [3:0]        out_keep;
    logic              out_valid, out_last, out_ready;
    logic [15:0]       out_len;
    logic              err_len;

    udp_ip_tx_framer #(.NUM_CH(NCH), .MAX_PAYLOAD(MAXP), .TTL(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_len(in_len),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port),
        .dst_port_base(dst_port_base), .out_data(out_data), .out_keep(out_keep),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .out_len(out_len), .err_len(err_len)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_cmp = 0, n_bad = 0;
    word_t       txq[NCH][$];
    logic [36:0] cap[$], expq[$];
    int          cap_cyc[$];
    int          cyc = 0, req_cyc = -1, ov_cyc = -1;
    int          n_err = 0, exp_err = 0, gap_pct = 0, rdy_mode = 0;
    logic [15:0] exp_ident = 16'd0;
    logic        stall_pend = 1'b0;
    logic [37:0] stall_word;
    logic [3:0]  ktab [4] = '{4'hF, 4'h8, 4'hC, 4'hE};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_csum(input int len, input logic [15:0] id);
`ifdef UDP_IP_TX_CHECKSUM_EN
        int unsigned s;
        s = 32'h4500 + 32'(28 + len) + 32'(id) + 32'h4000 + 32'h4011
          + 32'(src_ip[31:16]) + 32'(src_ip[15:0]) + 32'(dst_ip[31:16]) + 32'(dst_ip[15:0]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~16'(s);
`else
        return 16'(len - len) | 16'(id & 16'h0);
`endif
    endfunction

    function automatic int pending();
        int n = 0;
        for (int c = 0; c < NCH; c++) n += txq[c].size();
        return n;
    endfunction

    task automatic exp_push(input logic [31:0] d, input logic [3:0] k, input logic l);
        expq.push_back({d, k, l});
    endtask

    // Queue a packet of nsent words on channel c and append its expected frame
    task automatic send_pkt(input int c, input int len, input int nsent, input logic [31:0] w0);
        word_t w;
        logic [31:0] d[$];
        int e, n_out;
        for (int i = 0; i < nsent; i++) begin
            w.d = (i == 0) ? w0 : $urandom();
            w.last = (i == nsent - 1);
            w.len = 16'(len);
            w.first = (i == 0);
            txq[c].push_back(w);
            d.push_back(w.d);
        end
        if (len == 0 || len > MAXP) begin
            exp_err++;
            return;
        end
        e = (len + 3) / 4;
        exp_push({8'h45, 8'h00, 16'(28 + len)}, 4'hF, 1'b0);
        exp_push({exp_ident, 16'h4000}, 4'hF, 1'b0);
        exp_push({8'd64, 8'h11, ref_csum(len, exp_ident)}, 4'hF, 1'b0);
        exp_push(src_ip, 4'hF, 1'b0);
        exp_push(dst_ip, 4'hF, 1'b0);
        exp_push({src_port, 16'(32'(dst_port_base) + 32'(c))}, 4'hF, 1'b0);
        exp_push({16'(8 + len), 16'h0000}, 4'hF, 1'b0);
        exp_ident = exp_ident + 16'd1;
        n_out = (nsent < e) ? nsent : e;
        for (int i = 0; i < n_out; i++)
            exp_push(d[i], (i == e - 1) ? ktab[len % 4] : 4'hF, i == n_out - 1);
        if (nsent != e) exp_err++;
    endtask

    // One clock: sample at negedge, drive at posedge+1
    task automatic step();
        logic [NCH-1:0] acc;
        word_t w;
        @(negedge clk);
        cyc++;
        if (stall_pend) begin
            chk("stall_hold", 64'({out_valid, out_data, out_keep, out_last}), 64'(stall_word));
            stall_pend = 1'b0;
        end
        if (out_valid && !out_ready) begin
            stall_pend = 1'b1;
            stall_word = {1'b1, out_data, out_keep, out_last};
        end
        if (out_valid && out_ready) begin
            cap.push_back({out_data, out_keep, out_last});
            cap_cyc.push_back(cyc);
        end
        if (out_valid && ov_cyc < 0) ov_cyc = cyc;
        if (in_valid != '0 && req_cyc < 0) req_cyc = cyc;
        if (err_len) n_err++;
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (acc[c]) void'(txq[c].pop_front());
            if (txq[c].size() == 0) in_valid[c] = 1'b0;
            else if (acc[c] || !in_valid[c]) begin
                w = txq[c][0];
                in_valid[c] = w.first || ($urandom_range(99) >= 32'(gap_pct));
                in_data[32*c +: 32] = w.d;
                in_last[c] = w.last;
                in_len[16*c +: 16] = w.len;
            end
        end
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic run_done(input int budget);
        int quiet = 0, n = 0;
        while (quiet < 8 && n < budget) begin
            step();
            n++;
            if (pending() == 0 && !out_valid) quiet++;
            else quiet = 0;
        end
        if (quiet < 8) chk("timeout", 64'd1, 64'd0);
    endtask

    task automatic compare_all(input string tag);
        int n;
        chk({tag, "_nwords"}, 64'(cap.size()), 64'(expq.size()));
        n = (cap.size() < expq.size()) ? cap.size() : expq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(cap[i]), 64'(expq[i]));
        chk({tag, "_err"}, 64'(n_err), 64'(exp_err));
        chk({tag, "_drained"}, 64'(pending()), 64'd0);
        cap.delete(); cap_cyc.delete(); expq.delete();
        n_err = 0; exp_err = 0;
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < NCH; c++) txq[c].delete();
        in_valid = '0; in_last = '0; stall_pend = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) step();
        rst_n = 1'b1;
        exp_ident = 16'd0;
        cap.delete(); cap_cyc.delete(); expq.delete();
        n_err = 0; exp_err = 0;
    endtask

    int e, ns, ln, guard;

    initial begin
        rst_n = 1'b0; in_data = '0; in_len = '0; in_valid = '0; in_last = '0;
        out_ready = 1'b1; src_ip = 32'hC0A80101; dst_ip = 32'hC0A80102;
        src_port = 16'd12345; dst_port_base = 16'd12346;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_keep", 64'(out_keep), 64'd0);
        chk("rst_out_len", 64'(out_len), 64'd0);
        @(posedge clk); #1;
        reset_dut();

        // Single 4-byte packet on ch0
        req_cyc = -1; ov_cyc = -1;
        send_pkt(0, 4, 1, 32'hDEADBEEF);
        run_done(200);
        chk("t1_latency", 64'(ov_cyc - req_cyc), 64'(LAT));
        chk("t1_out_len", 64'(out_len), 64'd32);
        if (cap.size() == 8) begin
            chk("t1_w0", 64'(cap[0][36:5]), 64'h45000020);
            chk("t1_w1", 64'(cap[1][36:5]), 64'h00004000);
`ifdef UDP_IP_TX_CHECKSUM_EN
            chk("t1_w2", 64'(cap[2][36:5]), 64'h4011B779);
`else
            chk("t1_w2", 64'(cap[2][36:5]), 64'h40110000);
`endif
            chk("t1_w6", 64'(cap[6][36:5]), 64'h000C0000);
            chk("t1_w7", 64'(cap[7]), 64'({32'hDEADBEEF, 4'hF, 1'b1}));
        end
        compare_all("t1");

        // 5-byte packet: two payload words, last keeps one byte
        send_pkt(0, 5, 2, 32'h01020304);
        run_done(200);
        if (cap.size() == 9) chk("t2_keep", 64'(cap[8][4:1]), 64'h8);
        compare_all("t2");

        // Two channels requesting together, back-to-back frames
        reset_dut();
        send_pkt(0, 8, 2, 32'hA0A0A0A0);
        send_pkt(1, 8, 2, 32'hB1B1B1B1);
        run_done(300);
        if (cap.size() == 18) begin
            chk("t3_b2b", 64'(cap_cyc[9] - cap_cyc[8]), 64'(1 + LAT));
            chk("t3_port1", 64'(cap[14][20:5]), 64'(16'd12347));
        end
        compare_all("t3");

        // out_ready toggling every cycle
        rdy_mode = 1;
        send_pkt(0, 4, 1, 32'hDEADBEEF);
        send_pkt(0, 7, 2, 32'h11223344);
        run_done(400);
        compare_all("t4");
        rdy_mode = 0;

        // Zero and oversize lengths are dropped
        ov_cyc = -1;
        send_pkt(0, 0, 1, 32'h0);
        send_pkt(1, 1500, 3, 32'h0);
        run_done(200);
        chk("t5_no_valid", 64'(ov_cyc < 0), 64'd1);
        compare_all("t5");

        // Early in_last, then count reached without in_last
        send_pkt(0, 12, 2, 32'hCAFEF00D);
        run_done(200);
        compare_all("t6a");
        send_pkt(1, 4, 2, 32'h55AA55AA);
        run_done(200);
        compare_all("t6b");

        // Randomized alternating traffic with gaps and backpressure
        reset_dut();
        src_ip = $urandom(); dst_ip = $urandom();
        src_port = 16'($urandom()); dst_port_base = 16'hFFFF;
        gap_pct = 30; rdy_mode = 2;
        for (int k = 0; k < 12; k++) begin
            for (int c = 0; c < NCH; c++) begin
                ln = (k == 3 && c == 1) ? 0 : 32'($urandom_range(1, 64));
                e = (ln + 3) / 4;
                case ($urandom_range(9))
                    0: ns = e + 1;
                    1: ns = (e > 1) ? e - 1 : e;
                    default: ns = (e == 0) ? 1 : e;
                endcase
                send_pkt(c, ln, ns, $urandom());
            end
        end
        run_done(20000);
        compare_all("t7");
        gap_pct = 0; rdy_mode = 0;

        // Reset during payload aborts; next packet starts at ident 0
        send_pkt(0, 40, 10, 32'h12345678);
        guard = 0;
        while (cap.size() < 9 && guard < 200) begin
            step();
            guard++;
        end
        chk("t8_reached_pay", 64'(cap.size() >= 9), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t8_out_valid", 64'(out_valid), 64'd0);
        chk("t8_in_ready", 64'(in_ready), 64'd0);
        chk("t8_out_last", 64'(out_last), 64'd0);
        chk("t8_out_data", 64'(out_data), 64'd0);
        chk("t8_out_len", 64'(out_len), 64'd0);
        @(posedge clk); #1;
        reset_dut();
        send_pkt(1, 6, 2, 32'h9ABCDEF0);
        run_done(200);
        if (cap.size() >= 2) chk("t8_ident0", 64'(cap[1][36:21]), 64'd0);
        compare_all("t8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
